// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetch owns its slots,
// CPU and draw engine share the remaining cycles round-robin.
module vram_arbiter #(
    parameter int AW       = 17,
    parameter int DW       = 16,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WPL      = H_ACTIVE / 4
) (
    input  logic          ckVideo,
    input  logic          rst,
    input  logic [9:0]    adrHor,
    input  logic [9:0]    adrVer,
    output logic [DW-1:0] dispWord,
    output logic          dispValid,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuAdr,
    input  logic [DW-1:0] cpuWdata,
    output logic          cpuGnt,
    output logic [DW-1:0] cpuRdata,
    output logic          cpuRvalid,
    input  logic          drwReq,
    input  logic [AW-1:0] drwAdr,
    input  logic [DW-1:0] drwWdata,
    output logic          drwGnt,
    output logic [AW-1:0] ramAdr,
    output logic          ramWe,
    output logic [DW-1:0] ramWdata,
    input  logic [DW-1:0] ramRdata
);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_CPU
    } tag_t;

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    logic          disp_slot;
    logic [AW-1:0] disp_adr;
    logic          cpu_elig;
    logic          drw_elig;
    logic          pick_cpu;
    logic          pick_drw;
    logic          last_gnt;
    tag_t          tag_cmd;
    tag_t          tag_ret;

    assign disp_slot = (adrHor < H_LIM) && (adrVer < V_LIM)
                    && (adrHor[1:0] == 2'b00);
    assign disp_adr  = AW'(adrVer) * AW'(WPL) + AW'(adrHor[9:2]);

    // A requester whose grant is on the bus right now may be dropping
    // its request; skipping it this cycle avoids a double grant.
    assign cpu_elig = cpuReq && !cpuGnt;
    assign drw_elig = drwReq && !drwGnt;

    // last_gnt: 0 = CPU won last, 1 = draw engine won last
    assign pick_cpu = !disp_slot && cpu_elig && (!drw_elig || last_gnt);
    assign pick_drw = !disp_slot && drw_elig && (!cpu_elig || !last_gnt);

    always_ff @(posedge ckVideo) begin
        if (rst) begin
            ramAdr   <= '0;
            ramWe    <= 1'b0;
            ramWdata <= '0;
            cpuGnt   <= 1'b0;
            drwGnt   <= 1'b0;
            last_gnt <= 1'b1;
            tag_cmd  <= TAG_NONE;
            tag_ret  <= TAG_NONE;
        end else begin
            cpuGnt  <= pick_cpu;
            drwGnt  <= pick_drw;
            tag_ret <= tag_cmd;
            if (disp_slot) begin
                ramAdr  <= disp_adr;
                ramWe   <= 1'b0;
                tag_cmd <= TAG_DISP;
            end else if (pick_cpu) begin
                ramAdr   <= cpuAdr;
                ramWe    <= cpuWe;
                ramWdata <= cpuWdata;
                tag_cmd  <= cpuWe ? TAG_NONE : TAG_CPU;
                last_gnt <= 1'b0;
            end else if (pick_drw) begin
                ramAdr   <= drwAdr;
                ramWe    <= 1'b1;
                ramWdata <= drwWdata;
                tag_cmd  <= TAG_NONE;
                last_gnt <= 1'b1;
            end else begin
                ramWe   <= 1'b0;
                tag_cmd <= TAG_NONE;
            end
        end
    end

    // Valids are masked while reset is held so no stale read leaks out.
    assign dispWord  = ramRdata;
    assign cpuRdata  = ramRdata;
    assign dispValid = !rst && (tag_ret == TAG_DISP);
    assign cpuRvalid = !rst && (tag_ret == TAG_CPU);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, behavioural reference model
// compared every cycle, plus directed literal checks.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  adrHor;
    logic [9:0]  adrVer;
    logic [15:0] dispWord;
    logic        dispValid;
    logic        cpuReq;
    logic        cpuWe;
    logic [16:0] cpuAdr;
    logic [15:0] cpuWdata;
    logic        cpuGnt;
    logic [15:0] cpuRdata;
    logic        cpuRvalid;
    logic        drwReq;
    logic [16:0] drwAdr;
    logic [15:0] drwWdata;
    logic        drwGnt;
    logic [16:0] ramAdr;
    logic        ramWe;
    logic [15:0] ramWdata;
    logic [15:0] ramRdata = 16'h0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .ckVideo  (clk),
        .rst      (rst),
        .adrHor   (adrHor),
        .adrVer   (adrVer),
        .dispWord (dispWord),
        .dispValid(dispValid),
        .cpuReq   (cpuReq),
        .cpuWe    (cpuWe),
        .cpuAdr   (cpuAdr),
        .cpuWdata (cpuWdata),
        .cpuGnt   (cpuGnt),
        .cpuRdata (cpuRdata),
        .cpuRvalid(cpuRvalid),
        .drwReq   (drwReq),
        .drwAdr   (drwAdr),
        .drwWdata (drwWdata),
        .drwGnt   (drwGnt),
        .ramAdr   (ramAdr),
        .ramWe    (ramWe),
        .ramWdata (ramWdata),
        .ramRdata (ramRdata)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Synchronous RAM macro: read-before-write, 1-cycle read latency
    logic [15:0] ram [int];
    always @(posedge clk) begin
        logic [15:0] rd;
        rd = ram.exists(int'(ramAdr)) ? ram[int'(ramAdr)] : 16'h0;
        if (ramWe === 1'b1) ram[int'(ramAdr)] = ramWdata;
        ramRdata <= rd;
    end

    // Reference model: who owns each cycle, what the RAM holds,
    // and which read comes back when.
    logic [15:0] mmem [int];
    bit          started = 0;
    bit          m_cg, m_dg, m_we;
    bit          m_last_cpu;
    logic [16:0] m_adr;
    logic [15:0] m_wd;
    int          p1_kind, p0_kind;
    logic [15:0] p1_data, p0_data;

    function automatic logic [15:0] mrd(input int a);
        return mmem.exists(a) ? mmem[a] : 16'h0;
    endfunction

    always @(posedge clk) begin
        bit c_ok, d_ok, slot;
        int win, a;
        started = 1;
        if (rst) begin
            m_cg = 0; m_dg = 0; m_we = 0;
            m_adr = '0; m_wd = '0;
            m_last_cpu = 0;
            p0_kind = 0; p1_kind = 0;
        end else begin
            slot = (adrHor < 640) && (adrVer < 480) && (adrHor % 4 == 0);
            c_ok = cpuReq && !m_cg;
            d_ok = drwReq && !m_dg;
            win = 0;
            if (!slot) begin
                if (c_ok && d_ok) win = m_last_cpu ? 2 : 1;
                else if (c_ok) win = 1;
                else if (d_ok) win = 2;
            end
            p0_kind = p1_kind; p0_data = p1_data;
            p1_kind = 0;
            if (slot) begin
                a = int'(adrVer) * 160 + int'(adrHor) / 4;
                m_adr = 17'(a); m_we = 0;
                p1_kind = 1; p1_data = mrd(a);
            end else if (win == 1) begin
                m_adr = cpuAdr; m_we = cpuWe; m_last_cpu = 1;
                if (cpuWe) begin
                    m_wd = cpuWdata; mmem[int'(cpuAdr)] = cpuWdata;
                end else begin
                    p1_kind = 2; p1_data = mrd(int'(cpuAdr));
                end
            end else if (win == 2) begin
                m_adr = drwAdr; m_we = 1; m_last_cpu = 0;
                m_wd = drwWdata; mmem[int'(drwAdr)] = drwWdata;
            end else begin
                m_we = 0;
            end
            m_cg = (win == 1);
            m_dg = (win == 2);
        end
    end

    always @(negedge clk) begin
        bit edv, ecv;
        if (started) begin
            edv = (p0_kind == 1) && !rst;
            ecv = (p0_kind == 2) && !rst;
            chk("m_cpuGnt", 32'(cpuGnt), 32'(m_cg));
            chk("m_drwGnt", 32'(drwGnt), 32'(m_dg));
            chk("m_ramWe", 32'(ramWe), 32'(m_we));
            chk("m_ramAdr", 32'(ramAdr), 32'(m_adr));
            if (m_we) chk("m_ramWdata", 32'(ramWdata), 32'(m_wd));
            chk("m_dispValid", 32'(dispValid), 32'(edv));
            chk("m_cpuRvalid", 32'(cpuRvalid), 32'(ecv));
            if (edv) chk("m_dispWord", 32'(dispWord), 32'(p0_data));
            if (ecv) chk("m_cpuRdata", 32'(cpuRdata), 32'(p0_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ram[0] = 16'hA5A5;     mmem[0] = 16'hA5A5;
        ram[76799] = 16'h7E57; mmem[76799] = 16'h7E57;
        ram[291] = 16'hBEEF;   mmem[291] = 16'hBEEF;
        for (int i = 480; i < 486; i++) begin
            ram[i] = 16'(16'hC000 + i);
            mmem[i] = 16'(16'hC000 + i);
        end

        // reset with both requesters active
        rst = 1; adrHor = 0; adrVer = 500;
        cpuReq = 1; cpuWe = 1; cpuAdr = 17'h55; cpuWdata = 16'h1234;
        drwReq = 1; drwAdr = 17'h300; drwWdata = 16'h2222;
        repeat (3) tick();
        chk("rst_cpuGnt", 32'(cpuGnt), 0);
        chk("rst_drwGnt", 32'(drwGnt), 0);
        chk("rst_ramWe", 32'(ramWe), 0);
        chk("rst_dispValid", 32'(dispValid), 0);
        chk("rst_cpuRvalid", 32'(cpuRvalid), 0);

        // display slot blocks the CPU, which wins the next cycle
        rst = 0; adrVer = 0; adrHor = 0; drwReq = 0;
        tick();
        chk("slot_ramAdr", 32'(ramAdr), 0);
        chk("slot_ramWe", 32'(ramWe), 0);
        chk("slot_cpuGnt", 32'(cpuGnt), 0);
        adrHor = 1;
        tick();
        chk("t2_cpuGnt", 32'(cpuGnt), 1);
        chk("t2_ramWe", 32'(ramWe), 1);
        chk("t2_ramAdr", 32'(ramAdr), 32'h55);
        chk("t2_dispValid", 32'(dispValid), 1);
        chk("t2_dispWord", 32'(dispWord), 32'hA5A5);
        cpuReq = 0; adrHor = 2;
        tick();

        // last display word of the frame
        adrHor = 636; adrVer = 479;
        tick();
        chk("last_ramAdr", 32'(ramAdr), 76799);
        adrHor = 700;
        tick();
        chk("last_dispValid", 32'(dispValid), 1);
        chk("last_dispWord", 32'(dispWord), 32'h7E57);

        // blanking, both writers held: strict alternation, CPU first
        adrVer = 500; adrHor = 0; rst = 1;
        cpuReq = 1; cpuWe = 1; cpuAdr = 17'h200; cpuWdata = 16'h1111;
        drwReq = 1;
        tick();
        chk("rr_rst_cpuGnt", 32'(cpuGnt), 0);
        chk("rr_rst_drwGnt", 32'(drwGnt), 0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_cpuGnt", 32'(cpuGnt), 32'(i % 2 == 0));
            chk("rr_drwGnt", 32'(drwGnt), 32'(i % 2 == 1));
        end

        // CPU read returns RAM data one cycle after the command
        cpuReq = 0; drwReq = 0;
        tick();
        cpuReq = 1; cpuWe = 0; cpuAdr = 17'h00123;
        tick();
        chk("rd_cpuGnt", 32'(cpuGnt), 1);
        chk("rd_ramAdr", 32'(ramAdr), 32'h123);
        chk("rd_ramWe", 32'(ramWe), 0);
        cpuReq = 0;
        tick();
        chk("rd_cpuRvalid", 32'(cpuRvalid), 1);
        chk("rd_cpuRdata", 32'(cpuRdata), 32'hBEEF);

        // active line with both requesters held between display slots
        adrVer = 3;
        cpuReq = 1; cpuWe = 0; cpuAdr = 17'h55;
        drwReq = 1; drwAdr = 17'h600; drwWdata = 16'hD00D;
        for (int h = 0; h < 24; h++) begin
            adrHor = 10'(h);
            tick();
        end

        // reset right after a CPU read grant discards the read
        cpuReq = 0; drwReq = 0; adrVer = 500; adrHor = 0;
        tick();
        cpuReq = 1; cpuWe = 0; cpuAdr = 17'h123;
        tick();
        chk("rr6_cpuGnt", 32'(cpuGnt), 1);
        cpuReq = 0; rst = 1;
        tick();
        chk("t6_cpuRvalid", 32'(cpuRvalid), 0);
        chk("t6_cpuGnt", 32'(cpuGnt), 0);
        chk("t6_ramAdr", 32'(ramAdr), 0);
        chk("t6_ramWe", 32'(ramWe), 0);
        chk("t6_ramWdata", 32'(ramWdata), 0);
        rst = 0;
        tick();
        chk("t6_post_cpuRvalid", 32'(cpuRvalid), 0);
        tick();
        chk("t6_post2_cpuRvalid", 32'(cpuRvalid), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
